piso_bit_serializer: RTL and testbench



---
 rtl/piso_bit_serializer.sv | 212 +++++++++++++++++++++
 tb/tb_piso_bit_serializer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_bit_serializer.sv
// -----------------------------------------------------------------------------
// piso_bit_serializer
//
// Parallel-in / serial-out front end for the bit-serial sequence detectors.
// A WIDTH-bit word is taken over a valid/ready handshake and shifted out one
// bit per clock on sout. Between words sout is held at 0 so the downstream
// detector falls back to idle. An optional fixed gap of GAP idle cycles can
// be forced after every word.
//
// Parameters
//   WIDTH      word width in bits (>= 1)
//   MSB_FIRST  1: din[WIDTH-1] leaves first, 0: din[0] leaves first
//   GAP        idle cycles forced after each word (>= 0)
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous, active-high reset
//   din         parallel word, sampled only on accept
//   din_valid   upstream presents a word on din
//   din_ready   block can accept a word this cycle (forced low while rst=1)
//   sout        serial data bit (0 whenever no word bit is on the line)
//   sout_valid  sout carries a word bit this cycle
//   bit_idx     shift-order index of the bit on sout, 0 when not shifting
//   last        final bit of the word is on sout
//   busy        shifting a word or sitting in the inter-word gap
// -----------------------------------------------------------------------------
module piso_bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int GAP       = 0,
   localparam int IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic [IW-1:0]    bit_idx,
   output logic             last,
   output logic             busy
);

   // Gap counter only has to reach GAP-1; keep at least one bit so the
   // declaration stays legal when GAP is 0 or 1.
   localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [IW-1:0] BIT_LAST = IW'(WIDTH - 1);
   localparam logic [IW-1:0] BIT_ONE  = IW'(1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] shreg_r;
   logic [WIDTH-1:0] shreg_s;
   logic [IW-1:0]    cnt_r;
   logic [IW-1:0]    cnt_s;
   logic [GW-1:0]    gcnt_r;
   logic [GW-1:0]    gcnt_s;
   logic             ready_r;
   logic             ready_s;
   logic             accept_s;

   logic             sout_r;
   logic             sout_valid_r;
   logic [IW-1:0]    bit_idx_r;
   logic             last_r;
   logic             busy_r;

   // Bit currently at the head of the shift register in shift order.
   function automatic logic head_bit(input logic [WIDTH-1:0] v);
      logic h;
      if (MSB_FIRST) begin
         h = v[WIDTH-1];
      end else begin
         h = v[0];
      end
      return h;
   endfunction

   // Advance the shift register by one position in shift order.
   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      if (MSB_FIRST) begin
         r = v << 1'b1;
      end else begin
         r = v >> 1'b1;
      end
      return r;
   endfunction

   // ready_r is decoded from registered state, so din_valid never reaches
   // din_ready combinationally; only rst gates it.
   assign din_ready = ready_r & ~rst;
   assign accept_s  = din_valid & din_ready;

   // Next-state computation for the state register, shifter and counters.
   always_comb begin
      state_s = state_r;
      shreg_s = shreg_r;
      cnt_s   = cnt_r;
      gcnt_s  = gcnt_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = ST_SHIFT;
               shreg_s = din;
               cnt_s   = {IW{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_r == BIT_LAST) begin
               if (GAP == 0) begin
                  // Zero-bubble streaming: a word offered during the last
                  // bit follows on the very next cycle.
                  if (accept_s) begin
                     state_s = ST_SHIFT;
                     shreg_s = din;
                     cnt_s   = {IW{1'b0}};
                  end else begin
                     state_s = ST_IDLE;
                     shreg_s = {WIDTH{1'b0}};
                     cnt_s   = {IW{1'b0}};
                  end
               end else begin
                  state_s = ST_GAP;
                  shreg_s = {WIDTH{1'b0}};
                  cnt_s   = {IW{1'b0}};
                  gcnt_s  = {GW{1'b0}};
               end
            end else begin
               shreg_s = shift_once(shreg_r);
               cnt_s   = cnt_r + BIT_ONE;
            end
         end
         ST_GAP: begin
            if (gcnt_r == GAP_LAST) begin
               gcnt_s = {GW{1'b0}};
               if (accept_s) begin
                  state_s = ST_SHIFT;
                  shreg_s = din;
                  cnt_s   = {IW{1'b0}};
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               gcnt_s = gcnt_r + GAP_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            shreg_s = {WIDTH{1'b0}};
            cnt_s   = {IW{1'b0}};
            gcnt_s  = {GW{1'b0}};
         end
      endcase
   end

   // Ready for the cycle after the edge, derived from the next state only.
   always_comb begin
      ready_s = 1'b0;
      case (state_s)
         ST_IDLE:  ready_s = 1'b1;
         ST_SHIFT: ready_s = (cnt_s == BIT_LAST) && (GAP == 0);
         ST_GAP:   ready_s = (gcnt_s == GAP_LAST);
         default:  ready_s = 1'b0;
      endcase
   end

   // FSM state, datapath registers and registered output decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         shreg_r      <= {WIDTH{1'b0}};
         cnt_r        <= {IW{1'b0}};
         gcnt_r       <= {GW{1'b0}};
         ready_r      <= 1'b1;
         sout_r       <= 1'b0;
         sout_valid_r <= 1'b0;
         bit_idx_r    <= {IW{1'b0}};
         last_r       <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         shreg_r      <= shreg_s;
         cnt_r        <= cnt_s;
         gcnt_r       <= gcnt_s;
         ready_r      <= ready_s;
         sout_r       <= (state_s == ST_SHIFT) ? head_bit(shreg_s) : 1'b0;
         sout_valid_r <= (state_s == ST_SHIFT);
         bit_idx_r    <= (state_s == ST_SHIFT) ? cnt_s : {IW{1'b0}};
         last_r       <= (state_s == ST_SHIFT) && (cnt_s == BIT_LAST);
         busy_r       <= (state_s != ST_IDLE);
      end
   end

   assign sout       = sout_r;
   assign sout_valid = sout_valid_r;
   assign bit_idx    = bit_idx_r;
   assign last       = last_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_bit_serializer
//
// Three serializer instances run side by side:
//   lane 0: WIDTH=8, MSB_FIRST=1, GAP=0
//   lane 1: WIDTH=8, MSB_FIRST=0, GAP=2
//   lane 2: WIDTH=1, MSB_FIRST=1, GAP=0
// Each lane keeps a reference schedule: one entry per future clock cycle of
// what the line should show. An accepted word appends its WIDTH bit cycles
// and GAP idle cycles; the monitor pops one entry per cycle and compares.
// The block is ready exactly when nothing is scheduled beyond the current
// cycle.
// -----------------------------------------------------------------------------
module tb_piso_bit_serializer;

   typedef struct {
      logic v;
      logic b;
      int   idx;
      logic l;
      logic bz;
   } ent_t;

   logic clk;
   int   vectors;
   int   miscompares;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      vectors     = 0;
      miscompares = 0;
   end

   function automatic void chk(input int lane, input string nm,
                               input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL lane%0d %s: got %0h expected %0h", lane, nm, act, exp);
      end
   endfunction

   for (genvar g = 0; g < 3; g++) begin : lane
      localparam int W  = (g == 2) ? 1 : 8;
      localparam bit MF = (g == 1) ? 1'b0 : 1'b1;
      localparam int GP = (g == 1) ? 2 : 0;
      localparam int IW = (W > 1) ? $clog2(W) : 1;

      logic          rst_t;
      logic          dv;
      logic [W-1:0]  din;
      logic          rdy;
      logic          so;
      logic          sv;
      logic [IW-1:0] bi;
      logic          lst;
      logic          bz;
      bit            en;
      bit            done;
      ent_t          sched[$];

      piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(MF), .GAP(GP)) dut (
         .clk        (clk),
         .rst        (rst_t),
         .din        (din),
         .din_valid  (dv),
         .din_ready  (rdy),
         .sout       (so),
         .sout_valid (sv),
         .bit_idx    (bi),
         .last       (lst),
         .busy       (bz)
      );

      // Reference model: reset drops everything, otherwise accept when idle.
      always @(posedge clk) begin
         if (rst_t) begin
            sched.delete();
         end else if (dv && sched.size() == 0) begin
            for (int i = 0; i < W; i++) begin
               ent_t e;
               e.v   = 1'b1;
               e.b   = MF ? din[W-1-i] : din[i];
               e.idx = i;
               e.l   = (i == W - 1);
               e.bz  = 1'b1;
               sched.push_back(e);
            end
            for (int i = 0; i < GP; i++) begin
               sched.push_back('{1'b0, 1'b0, 0, 1'b0, 1'b1});
            end
         end
      end

      // Monitor: pop this cycle's expectation and compare every output.
      always @(negedge clk) begin
         if (en) begin
            ent_t e;
            if (sched.size() > 0) begin
               e = sched.pop_front();
            end else begin
               e = '{1'b0, 1'b0, 0, 1'b0, 1'b0};
            end
            chk(g, "sout",       32'(so),  32'(e.b));
            chk(g, "sout_valid", 32'(sv),  32'(e.v));
            chk(g, "bit_idx",    32'(bi),  32'(e.idx));
            chk(g, "last",       32'(lst), 32'(e.l));
            chk(g, "busy",       32'(bz),  32'(e.bz));
            chk(g, "din_ready",  32'(rdy), 32'(!rst_t && sched.size() == 0));
         end
      end

      task automatic cyc(input int n);
         repeat (n) begin
            @(posedge clk);
            #1;
         end
      endtask

      // Offer a word and hold valid until the edge at which it is taken.
      task automatic send(input logic [W-1:0] w);
         int n;
         din = w;
         dv  = 1'b1;
         n   = 0;
         while ((sched.size() > 1 || rst_t) && n < 200) begin
            cyc(1);
            n++;
         end
         if (n >= 200) chk(g, "ready_wait", 32'd0, 32'd1);
         cyc(1);
      endtask

      initial begin
         rst_t = 1'b1;
         dv    = 1'b0;
         din   = {W{1'b0}};
         en    = 1'b0;
         done  = 1'b0;
         if (g == 0) begin
            dv  = 1'b1;
            din = W'(8'hAA);
         end
         cyc(1);
         en = 1'b1;
         cyc(1);
         rst_t = 1'b0;
         if (g == 0) begin
            cyc(1);
            dv = 1'b0;
            send(W'(8'hB3));
            dv = 1'b0;
            cyc(12);
            send(W'(8'hFF));
            send(W'(8'h0F));
            dv = 1'b0;
            cyc(20);
            send(W'(8'hFF));
            dv = 1'b0;
            cyc(2);
            rst_t = 1'b1;
            cyc(1);
            rst_t = 1'b0;
            send(W'(8'h80));
            dv = 1'b0;
            cyc(12);
         end else if (g == 1) begin
            send(W'(8'h81));
            send(W'(8'h81));
            dv = 1'b0;
            cyc(14);
            send(W'(8'h01));
            dv = 1'b0;
            cyc(14);
         end else begin
            send(W'(1'b1));
            send(W'(1'b0));
            send(W'(1'b1));
            dv = 1'b0;
            cyc(5);
         end
         repeat (400) begin
            din   = W'($urandom);
            dv    = ($urandom_range(3, 0) != 0);
            rst_t = ($urandom_range(63, 0) == 0);
            cyc(1);
         end
         rst_t = 1'b0;
         dv    = 1'b0;
         cyc(W + GP + 4);
         done = 1'b1;
      end
   end

   initial begin
      int c;
      c = 0;
      while (!(lane[0].done && lane[1].done && lane[2].done) && c < 5000) begin
         @(posedge clk);
         c++;
      end
      if (c >= 5000) chk(-1, "finish_wait", 32'd0, 32'd1);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
